// File: rtl/bus_arbiter_mux_if.sv
// Purpose: request/data/handshake bundle between the bus sources, the arbiter and the bus consumer.
// Latency: none; signals only, no logic.
// Backpressure: bus_ready from the consumer stalls the arbiter's registered word.
interface bus_arbiter_mux_if #(
  parameter int NUM_SRC = 8,
  parameter int DATA_W  = 16
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        lock;
  logic                      force_en;
  logic [SEL_W-1:0]          force_sel;
  logic                      bus_ready;
  logic                      bus_valid;
  logic [DATA_W-1:0]         bus_data;
  logic [SEL_W-1:0]          bus_sel;
  logic [NUM_SRC-1:0]        grant;
  logic [NUM_SRC-1:0]        src_ack;

  // Source/consumer side: drives requests and ready, observes the bus.
  modport master (
    output req, src_data, lock, force_en, force_sel, bus_ready,
    input  bus_valid, bus_data, bus_sel, grant, src_ack
  );

  // Arbiter side.
  modport slave (
    input  req, src_data, lock, force_en, force_sel, bus_ready,
    output bus_valid, bus_data, bus_sel, grant, src_ack
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Purpose: round-robin arbiter with lock and force override, registering the winner's word onto a common bus.
// Latency: 1 cycle from request to bus_valid; back-to-back transfers with no bubble.
// Backpressure: while bus_ready=0 the captured word, owner and valid are held and new requests are ignored.
module bus_arbiter_mux #(
  parameter int NUM_SRC = 8,
  parameter int DATA_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  bus_arbiter_mux_if.slave bus
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  // Index a + b wrapped modulo NUM_SRC (b is always < NUM_SRC).
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return SEL_W'(s);
  endfunction

  state_t              r_state;
  logic                r_bus_valid;
  logic [DATA_W-1:0]   r_bus_data;
  logic [SEL_W-1:0]    r_bus_sel;
  logic [NUM_SRC-1:0]  r_grant;
  logic [SEL_W-1:0]    r_rr_ptr;
  logic                r_forced;   // current word was loaded through the force path

  logic [DATA_W-1:0]   w_src_word [NUM_SRC];
  logic                w_xfer;
  logic                w_force_ok;
  logic                w_lock_hold;
  logic                w_owner_req;
  logic [SEL_W-1:0]    w_owner_inc;
  logic [SEL_W-1:0]    w_rr_base;
  logic [NUM_SRC-1:0]  w_rr_mask;
  logic                w_rr_found;
  logic [SEL_W-1:0]    w_rr_idx;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    w_ptr_nxt;
  logic                w_load;
  logic                w_drop;
  logic [SEL_W-1:0]    w_win;
  logic                w_win_forced;
  logic [NUM_SRC-1:0]  w_win_onehot;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign w_src_word[g] = bus.src_data[g*DATA_W +: DATA_W];
  end

  assign w_xfer       = r_bus_valid & bus.bus_ready;
  // An out-of-range force index selects nothing rather than aliasing a source.
  assign w_force_ok   = bus.force_en && (int'(bus.force_sel) < NUM_SRC);
  assign w_owner_req  = bus.req[r_bus_sel];
  assign w_lock_hold  = !bus.force_en && bus.lock[r_bus_sel] && w_owner_req;
  assign w_owner_inc  = wrap_add(r_bus_sel, 1);
  assign w_win_onehot = NUM_SRC'(1) << w_win;

  // Search base and candidate set: on a completing transfer the pointer has
  // already moved past an unforced owner, and the owner itself is excluded.
  always_comb begin
    w_rr_base = r_rr_ptr;
    w_rr_mask = bus.req;
    if (r_state == BUSY) begin
      if (!r_forced) w_rr_base = w_owner_inc;
      w_rr_mask = bus.req & ~r_grant;
    end
  end

  // First requesting source at or after the search base, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_rr_found && w_rr_mask[wrap_add(w_rr_base, k)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = wrap_add(w_rr_base, k);
      end
    end
  end

  // Next state, pointer update and capture decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_rr_ptr;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    w_win        = r_bus_sel;
    w_win_forced = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_force_ok) begin
          w_load       = 1'b1;
          w_win        = bus.force_sel;
          w_win_forced = 1'b1;
          w_state_nxt  = BUSY;
        end else if (w_rr_found) begin
          w_load      = 1'b1;
          w_win       = w_rr_idx;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_xfer) begin
          if (w_lock_hold) begin
            // Locked owner keeps the bus; pointer stays put.
            w_load = 1'b1;
            w_win  = r_bus_sel;
          end else begin
            if (!r_forced) w_ptr_nxt = w_owner_inc;
            if (w_force_ok) begin
              w_load       = 1'b1;
              w_win        = bus.force_sel;
              w_win_forced = 1'b1;
            end else if (w_rr_found) begin
              w_load = 1'b1;
              w_win  = w_rr_idx;
            end else if (w_owner_req) begin
              // The completing owner is the only requester left.
              w_load = 1'b1;
              w_win  = r_bus_sel;
            end else begin
              w_drop      = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, pointer and bus word registers; bus_data keeps its last word when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bus_valid <= 1'b0;
      r_bus_data  <= '0;
      r_bus_sel   <= '0;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_forced    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_ptr_nxt;
      if (w_load) begin
        r_bus_valid <= 1'b1;
        r_bus_data  <= w_src_word[w_win];
        r_bus_sel   <= w_win;
        r_grant     <= w_win_onehot;
        r_forced    <= w_win_forced;
      end else if (w_drop) begin
        r_bus_valid <= 1'b0;
        r_grant     <= '0;
        r_forced    <= 1'b0;
      end
    end
  end

  assign bus.bus_valid = r_bus_valid;
  assign bus.bus_data  = r_bus_data;
  assign bus.bus_sel   = r_bus_sel;
  assign bus.grant     = r_grant;
  // A word dropped by reset is never acknowledged, so the ack is masked while reset is asserted.
  assign bus.src_ack   = r_grant & {NUM_SRC{w_xfer & rst_n}};

endmodule

// File: tb/tb_bus_arbiter_mux.sv
module tb_bus_arbiter_mux;
  localparam int NUM_SRC = 8;
  localparam int DATA_W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter_mux_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) bif ();

  bus_arbiter_mux #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_bus(input string tag, input logic v, input logic [2:0] s,
                         input logic [15:0] d, input logic [7:0] g);
    chk({tag, ".valid"}, 32'(bif.bus_valid), 32'(v));
    chk({tag, ".sel"},   32'(bif.bus_sel),   32'(s));
    chk({tag, ".data"},  32'(bif.bus_data),  32'(d));
    chk({tag, ".grant"}, 32'(bif.grant),     32'(g));
  endtask

  task automatic chk_ack(input string tag, input logic [7:0] a);
    chk({tag, ".ack"}, 32'(bif.src_ack), 32'(a));
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [15:0] v);
    bif.src_data[i*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    int rr_exp [6];
    rr_exp = '{0, 2, 7, 0, 2, 7};

    rst_n         = 1'b0;
    bif.req       = '0;
    bif.src_data  = '0;
    bif.lock      = '0;
    bif.force_en  = 1'b0;
    bif.force_sel = '0;
    bif.bus_ready = 1'b0;

    // Reset then idle
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk_bus("reset", 1'b0, 3'd0, 16'h0000, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle.valid", 32'(bif.bus_valid), 32'd0);
      chk("idle.grant", 32'(bif.grant), 32'd0);
      chk("idle.data", 32'(bif.bus_data), 32'h0);
    end

    // Single request from source 3
    set_src(3, 16'hBEEF);
    bif.req       = 8'h08;
    bif.bus_ready = 1'b1;
    #1;
    chk_ack("single.pre", 8'h00);
    cyc();
    bif.req = 8'h00;
    #1;
    chk_bus("single", 1'b1, 3'd3, 16'hBEEF, 8'h08);
    chk_ack("single", 8'h08);
    cyc();
    chk_bus("single.done", 1'b0, 3'd3, 16'hBEEF, 8'h00);
    chk_ack("single.done", 8'h00);

    // Round robin over sources 0,2,7 starting from a freshly reset pointer
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    set_src(0, 16'hA000);
    set_src(2, 16'hA002);
    set_src(7, 16'hA007);
    bif.req       = 8'h85;
    bif.bus_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 5) bif.req = 8'h00;
      #1;
      chk_bus("rr", 1'b1, 3'(rr_exp[i]), 16'(16'hA000 + rr_exp[i]), 8'(8'h01 << rr_exp[i]));
      chk_ack("rr", 8'(8'h01 << rr_exp[i]));
    end
    cyc();
    chk("rr.end.valid", 32'(bif.bus_valid), 32'd0);

    // Backpressure on source 5
    set_src(5, 16'h1234);
    bif.req       = 8'h20;
    bif.bus_ready = 1'b0;
    cyc();
    set_src(5, 16'h5678);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_bus("bp.hold", 1'b1, 3'd5, 16'h1234, 8'h20);
      chk_ack("bp.hold", 8'h00);
      cyc();
    end
    bif.bus_ready = 1'b1;
    bif.req       = 8'h00;
    #1;
    chk_ack("bp.accept", 8'h20);
    cyc();
    chk_bus("bp.done", 1'b0, 3'd5, 16'h1234, 8'h00);

    // Lock: source 1 keeps the bus, then releases to source 2
    set_src(1, 16'h1111);
    set_src(2, 16'h2222);
    bif.req       = 8'h06;
    bif.lock      = 8'h02;
    bif.bus_ready = 1'b1;
    cyc();
    chk_bus("lock.t1", 1'b1, 3'd1, 16'h1111, 8'h02);
    chk_ack("lock.t1", 8'h02);
    set_src(1, 16'h1112);
    cyc();
    chk_bus("lock.t2", 1'b1, 3'd1, 16'h1112, 8'h02);
    set_src(1, 16'h1113);
    cyc();
    chk_bus("lock.t3", 1'b1, 3'd1, 16'h1113, 8'h02);
    bif.lock = 8'h00;
    cyc();
    chk_bus("lock.rel", 1'b1, 3'd2, 16'h2222, 8'h04);
    chk("lock.rr_ptr", 32'(dut.r_rr_ptr), 32'd2);
    bif.req = 8'h00;
    cyc();
    chk("lock.end.valid", 32'(bif.bus_valid), 32'd0);

    // Force source 6 with no request; pointer must not move
    set_src(6, 16'h6666);
    bif.force_en  = 1'b1;
    bif.force_sel = 3'd6;
    bif.bus_ready = 1'b0;
    cyc();
    chk_bus("force", 1'b1, 3'd6, 16'h6666, 8'h40);
    bif.force_en  = 1'b0;
    bif.bus_ready = 1'b1;
    #1;
    chk_ack("force", 8'h40);
    cyc();
    chk("force.end.valid", 32'(bif.bus_valid), 32'd0);
    chk("force.rr_ptr", 32'(dut.r_rr_ptr), 32'd3);
    // Pointer 3 favours source 4 over source 0
    set_src(4, 16'h4444);
    bif.req       = 8'h11;
    bif.bus_ready = 1'b0;
    cyc();
    chk_bus("force.next", 1'b1, 3'd4, 16'h4444, 8'h10);

    // Reset while busy drops the word without an ack
    rst_n         = 1'b0;
    bif.bus_ready = 1'b1;
    #1;
    chk_ack("midrst", 8'h00);
    cyc();
    chk_bus("midrst", 1'b0, 3'd0, 16'h0000, 8'h00);
    rst_n         = 1'b1;
    bif.req       = 8'h00;
    bif.bus_ready = 1'b0;
    #1;
    chk_ack("midrst.after", 8'h00);
    cyc();
    chk("midrst.idle", 32'(bif.bus_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
